// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: datapath hazard information and memory ack in,
// pipeline register / PC controls, memory request and performance counters out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rd;
    logic             ex_mem_branch;
    logic             ex_mem_zero;
    logic             ex_mem_memread;
    logic             ex_mem_memwrite;
    logic             dmem_ack;

    logic             dmem_req;
    logic             pc_write;
    logic             pc_src;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_hold;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  id_rs1, id_rs2, id_ex_memread, id_ex_rd,
               ex_mem_branch, ex_mem_zero, ex_mem_memread, ex_mem_memwrite, dmem_ack,
        output dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
               ex_mem_hold, ex_mem_flush, mem_wb_flush, mem_err, stall_cycles, flush_events
    );

    modport slave (
        output id_rs1, id_rs2, id_ex_memread, id_ex_rd,
               ex_mem_branch, ex_mem_zero, ex_mem_memread, ex_mem_memwrite, dmem_ack,
        input  dmem_req, pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
               ex_mem_hold, ex_mem_flush, mem_wb_flush, mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, taken-branch flush, dmem req/ack
// with timeout. Define HAZARD_PERF_EN to enable the stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.master hz
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

    localparam int WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              mem_access;
    logic              load_use;
    logic              branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        mem_access   = hz.ex_mem_memread | hz.ex_mem_memwrite;
        load_use     = hz.id_ex_memread && (hz.id_ex_rd != 5'd0) &&
                       ((hz.id_ex_rd == hz.id_rs1) || (hz.id_ex_rd == hz.id_rs2));
        branch_taken = 1'b0;
        state_d      = state_q;
        wait_d       = wait_q;

        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.pc_src       = 1'b0;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_flush  = 1'b0;
        hz.ex_mem_hold  = 1'b0;
        hz.ex_mem_flush = 1'b0;
        hz.mem_wb_flush = 1'b0;
        hz.dmem_req     = 1'b0;
        hz.mem_err      = 1'b0;

        if (reset) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_ex_flush  = 1'b1;
            hz.ex_mem_flush = 1'b1;
            hz.mem_wb_flush = 1'b1;
            state_d         = RUN;
            wait_d          = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hz.ex_mem_branch && hz.ex_mem_zero) begin
                        branch_taken    = 1'b1;
                        hz.pc_src       = 1'b1;
                        hz.if_id_flush  = 1'b1;
                        hz.id_ex_flush  = 1'b1;
                        hz.ex_mem_flush = 1'b1;
                    end else begin
                        hz.dmem_req = mem_access;
                        if (mem_access && !hz.dmem_ack) begin
                            hz.pc_write     = 1'b0;
                            hz.if_id_write  = 1'b0;
                            hz.ex_mem_hold  = 1'b1;
                            hz.mem_wb_flush = 1'b1;
                            state_d         = MEM_WAIT;
                            wait_d          = '0;
                        end else if (load_use) begin
                            hz.pc_write    = 1'b0;
                            hz.if_id_write = 1'b0;
                            hz.id_ex_flush = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    hz.dmem_req = 1'b1;
                    if (hz.dmem_ack) begin
                        // Load-use masked by the memory stall is resolved in the release cycle.
                        state_d = RUN;
                        wait_d  = '0;
                        if (load_use) begin
                            hz.pc_write    = 1'b0;
                            hz.if_id_write = 1'b0;
                            hz.id_ex_flush = 1'b1;
                        end
                    end else begin
                        hz.pc_write     = 1'b0;
                        hz.if_id_write  = 1'b0;
                        hz.ex_mem_hold  = 1'b1;
                        hz.mem_wb_flush = 1'b1;
                        if (wait_q == WAIT_LAST) begin
                            state_d = MEM_ERR;
                            wait_d  = '0;
                        end else begin
                            wait_d = wait_q + WCNT_W'(1);
                        end
                    end
                end
                MEM_ERR: begin
                    hz.mem_err      = 1'b1;
                    hz.pc_write     = 1'b0;
                    hz.if_id_write  = 1'b0;
                    hz.ex_mem_flush = 1'b1;
                    hz.mem_wb_flush = 1'b1;
                    state_d         = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!hz.pc_write) stall_q <= stall_q + CNT_W'(1);
            if (branch_taken) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;

    typedef struct packed {
        logic             dmem_req;
        logic             pc_write;
        logic             pc_src;
        logic             if_id_write;
        logic             if_id_flush;
        logic             id_ex_flush;
        logic             ex_mem_hold;
        logic             ex_mem_flush;
        logic             mem_wb_flush;
        logic             mem_err;
        logic [CNT_W-1:0] stall_cycles;
        logic [CNT_W-1:0] flush_events;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz.master)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: access in flight, MEM_WAIT cycles spent, pending error cycle.
    bit          m_waiting = 0;
    int          m_waited  = 0;
    bit          m_err     = 0;
    int unsigned m_stalls  = 0;
    int unsigned m_flushes = 0;

    task automatic check(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic drive(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit idmr, input logic [4:0] rd, input bit br, input bit zr,
                         input bit mr, input bit mw, input bit ack);
        exp_t e;
        bit   hit;
        bit   use_hit;
        @(posedge clk);
        #1;
        reset              = rst;
        hz.id_rs1          = rs1;
        hz.id_rs2          = rs2;
        hz.id_ex_memread   = idmr;
        hz.id_ex_rd        = rd;
        hz.ex_mem_branch   = br;
        hz.ex_mem_zero     = zr;
        hz.ex_mem_memread  = mr;
        hz.ex_mem_memwrite = mw;
        hz.dmem_ack        = ack;

        e             = '0;
        e.pc_write    = 1'b1;
        e.if_id_write = 1'b1;
`ifdef HAZARD_PERF_EN
        e.stall_cycles = CNT_W'(m_stalls % (1 << CNT_W));
        e.flush_events = CNT_W'(m_flushes % (1 << CNT_W));
`endif
        hit     = idmr && (rd != 0) && (rd == rs1 || rd == rs2);
        use_hit = 0;

        if (rst) begin
            e.pc_write = 0; e.if_id_write = 0;
            e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1; e.mem_wb_flush = 1;
            m_waiting = 0; m_waited = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (m_err) begin
                e.mem_err = 1; e.pc_write = 0; e.if_id_write = 0;
                e.ex_mem_flush = 1; e.mem_wb_flush = 1;
                m_err = 0;
            end else if (m_waiting) begin
                e.dmem_req = 1;
                if (ack) begin
                    m_waiting = 0;
                    use_hit   = hit;
                end else begin
                    e.pc_write = 0; e.if_id_write = 0; e.ex_mem_hold = 1; e.mem_wb_flush = 1;
                    m_waited++;
                    if (m_waited == MEM_TIMEOUT) begin
                        m_waiting = 0;
                        m_err     = 1;
                    end
                end
            end else if (br && zr) begin
                e.pc_src = 1; e.if_id_flush = 1; e.id_ex_flush = 1; e.ex_mem_flush = 1;
                m_flushes++;
            end else begin
                if (mr || mw) begin
                    e.dmem_req = 1;
                    if (!ack) begin
                        e.pc_write = 0; e.if_id_write = 0; e.ex_mem_hold = 1; e.mem_wb_flush = 1;
                        m_waiting = 1;
                        m_waited  = 0;
                    end
                end
                if (!(mr || mw) || ack) use_hit = hit;
            end
            if (use_hit) begin
                e.pc_write = 0; e.if_id_write = 0; e.id_ex_flush = 1;
            end
            if (!e.pc_write) m_stalls++;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("dmem_req",     CNT_W'(hz.dmem_req),     CNT_W'(e.dmem_req));
                check("pc_write",     CNT_W'(hz.pc_write),     CNT_W'(e.pc_write));
                check("pc_src",       CNT_W'(hz.pc_src),       CNT_W'(e.pc_src));
                check("if_id_write",  CNT_W'(hz.if_id_write),  CNT_W'(e.if_id_write));
                check("if_id_flush",  CNT_W'(hz.if_id_flush),  CNT_W'(e.if_id_flush));
                check("id_ex_flush",  CNT_W'(hz.id_ex_flush),  CNT_W'(e.id_ex_flush));
                check("ex_mem_hold",  CNT_W'(hz.ex_mem_hold),  CNT_W'(e.ex_mem_hold));
                check("ex_mem_flush", CNT_W'(hz.ex_mem_flush), CNT_W'(e.ex_mem_flush));
                check("mem_wb_flush", CNT_W'(hz.mem_wb_flush), CNT_W'(e.mem_wb_flush));
                check("mem_err",      CNT_W'(hz.mem_err),      CNT_W'(e.mem_err));
                check("stall_cycles", hz.stall_cycles,         e.stall_cycles);
                check("flush_events", hz.flush_events,         e.flush_events);
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1;
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_ex_memread = 0; hz.id_ex_rd = '0;
        hz.ex_mem_branch = 0; hz.ex_mem_zero = 0; hz.ex_mem_memread = 0;
        hz.ex_mem_memwrite = 0; hz.dmem_ack = 0;

        repeat (2) drive(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
        idle(1);
        // load-use on rs2, then rd=x0 never stalls
        drive(0, 5'd0, 5'd5, 1, 5'd5, 0, 0, 0, 0, 0);
        idle(1);
        drive(0, 5'd0, 5'd7, 1, 5'd0, 0, 0, 0, 0, 0);
        // taken branch masks a load-use hit
        drive(0, 5'd5, 5'd0, 1, 5'd5, 1, 1, 0, 0, 0);
        idle(1);
        // ack after 3 low cycles
        repeat (3) drive(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0, 0);
        drive(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0, 1);
        idle(1);
        // store with zero-wait ack and concurrent load-use
        drive(0, 5'd9, 5'd2, 1, 5'd9, 0, 0, 0, 1, 1);
        // timeout: run stall + 4 waits + error cycle
        repeat (6) drive(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0, 0);
        idle(2);
        // load-use held through a stall, resolved on release
        repeat (2) drive(0, 5'd3, 5'd2, 1, 5'd3, 0, 0, 1, 0, 0);
        drive(0, 5'd3, 5'd2, 1, 5'd3, 0, 0, 1, 0, 1);
        idle(1);
        // reset in the 2nd MEM_WAIT cycle
        repeat (2) drive(0, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0, 0);
        repeat (2) drive(1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 0, 0);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(399) == 0),
                  5'($urandom_range(3)), 5'($urandom_range(3)),
                  ($urandom_range(1) == 1), 5'($urandom_range(3)),
                  ($urandom_range(3) == 0), ($urandom_range(1) == 1),
                  ($urandom_range(3) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(9) < 4));
        end
        idle(2);
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drained", CNT_W'(sb_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
